cnt_modn: RTL and testbench
===========================

Name: cnt_modn

Overview:
- Parametrised modulo-N counter. It is the general successor of the fixed mod-60 counter used in clock/timer datapaths.
- Adds:
  - count enable (tick input, typically driven by an NCO output pulse)
  - up/down direction
  - synchronous clear
  - parallel load with range clamp
  - registered carry/borrow pulse for cascading stages (sec -> min -> hour)
  - registered two-digit BCD output for 7-segment decode

Parameters:
- MOD, 60, modulus; legal 2..99; count range 0..MOD-1.
- WIDTH, 7, binary output width; must satisfy 2^WIDTH >= MOD (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per clk cycle while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled only when en is used.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  load value.
- out  output  WIDTH  current count, binary.
- bcd_tens  output  4  tens digit of out (0..9).
- bcd_ones  output  4  ones digit of out (0..9).
- co  output  1  one-cycle carry (up) / borrow (down) pulse.

Behaviour:
- Reset (rst_n low, asynchronous): out = 0, bcd_tens = 0, bcd_ones = 0, co = 0; held until rst_n rises. Reset mid-count discards state; the first clk edge after release behaves as from reset.
- All outputs are registered and updated on the rising edge of clk. There is no combinational path from any input to any output.
- Per-cycle priority: clr > load > en > hold.
  - clr = 1: out <- 0, co <- 0. Ignores load/en.
  - load = 1 (clr = 0): out <- load_val if load_val <= MOD-1, else out <- MOD-1 (clamp); co <- 0.
  - en = 1, up_dn = 1: out <- out+1; if out == MOD-1 then out <- 0 and co <- 1.
  - en = 1, up_dn = 0: out <- out-1; if out == 0 then out <- MOD-1 and co <- 1.
  - en = 0: out holds, co <- 0.
- co is high for exactly one cycle: the cycle in which out shows the wrapped value (0 when counting up, MOD-1 when counting down). With en held high, co repeats every MOD cycles.
- co is never asserted by clr, load, or hold, including a load to 0 or MOD-1.
- Cascade rule: the next stage's en = co of this stage. The next stage steps one clk after this stage wraps; this one-cycle skew is accepted.
- BCD outputs are registered from the same next-state value as out, so they are always consistent with out in the same cycle. bcd_tens = out/10 and bcd_ones = out%10, computed by a constant-bound subtract/compare (no runtime divider).
- Internal arithmetic is WIDTH+1 bits so out+1 cannot overflow before the compare. out never leaves 0..MOD-1 under any input sequence.
- Direction change mid-count takes effect on the next enabled cycle, with no extra latency or bubble.

Test Plan:
- Reset/hold: rst_n low 3 cycles, then en = 0 for 5 cycles -> out = 0, bcd = 0/0, co = 0 throughout. Assert rst_n asynchronously between edges -> outputs clear immediately.
- Up wrap (MOD = 60): en = 1, up_dn = 1 from 0 for 125 cycles -> out sequence 0..59,0..; co high exactly in cycles where out = 0 after 59 (cycles 60 and 120); bcd 5/9 at out = 59.
- Down wrap: load 2, then en = 1, up_dn = 0 -> out 1, 0, 59 with co = 1 only at 59, then 58; bcd 5/8.
- Priority/load clamp: same cycle clr = 1, load = 1, en = 1 -> out = 0, co = 0. Load 75 with MOD = 60 -> out = 59, co = 0. Next en up -> out = 0, co = 1.
- Cascade: two instances (MOD = 60, then MOD = 24), second en = first co, 60*24*2 enabled cycles -> second stage wraps 23 -> 0 exactly twice; its co pulses twice.
- Parameter sweep: MOD = 2, 10, 99 with matching WIDTH -> full up and down cycles. Out is never >= MOD, bcd always matches out, co period = MOD.

Source files
------------

// File: rtl/cnt_modn.sv
// Parametrised modulo-N up/down counter with clear, clamped load,
// registered carry/borrow pulse and registered two-digit BCD output.
module cnt_modn #(
   parameter int unsigned MOD   = 60,
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones,
   output logic             co
);

   localparam int unsigned W1 = WIDTH + 1;
   localparam logic [W1-1:0] TOP = W1'(MOD - 1);

   generate
      if (MOD < 2 || MOD > 99 || (64'd1 << WIDTH) < 64'(MOD)) begin : g_bad
         $error("cnt_modn: illegal MOD/WIDTH combination");
      end
   endgenerate

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic             co_q, co_d;

   logic [W1-1:0]    cur;
   logic [W1-1:0]    lv;
   logic [W1-1:0]    nxt;
   logic [7:0]       bcd8;

   // Value never exceeds 98, so nine conditional subtractions suffice.
   function automatic logic [7:0] bin2bcd(input logic [7:0] v);
      logic [7:0] r;
      logic [3:0] t;
      r = v;
      t = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (r >= 8'd10) begin
            r = r - 8'd10;
            t = t + 4'd1;
         end
      end
      return {t, r[3:0]};
   endfunction

   always_comb begin
      cur  = {1'b0, cnt_q};
      lv   = {1'b0, load_val};
      nxt  = cur;
      co_d = 1'b0;
      priority case (1'b1)
         clr: begin
            nxt = '0;
         end
         load: begin
            nxt = (lv > TOP) ? TOP : lv;
         end
         en: begin
            if (up_dn) begin
               if (cur == TOP) begin
                  nxt  = '0;
                  co_d = 1'b1;
               end else begin
                  nxt = cur + W1'(1);
               end
            end else begin
               if (cur == '0) begin
                  nxt  = TOP;
                  co_d = 1'b1;
               end else begin
                  nxt = cur - W1'(1);
               end
            end
         end
         default: begin
            nxt = cur;
         end
      endcase
      cnt_d  = nxt[WIDTH-1:0];
      bcd8   = bin2bcd(8'(nxt));
      tens_d = bcd8[7:4];
      ones_d = bcd8[3:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tens_q <= 4'd0;
         ones_q <= 4'd0;
         co_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tens_q <= tens_d;
         ones_q <= ones_d;
         co_q   <= co_d;
      end
   end

   assign out      = cnt_q;
   assign bcd_tens = tens_q;
   assign bcd_ones = ones_q;
   assign co       = co_q;

endmodule

// File: tb/tb_cnt_modn.sv
// Directed self-checking bench for cnt_modn: reset, wraps, priority,
// clamp, cascade and a small MOD sweep.
module tb_cnt_modn;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, up_dn, clr, load;
   logic [6:0] load_val;

   logic [6:0] out;
   logic [3:0] tens, ones;
   logic       co;

   logic [0:0] lv2;
   logic [0:0] o2;
   logic [3:0] t2, n2;
   logic       c2;
   logic [3:0] lv10, o10;
   logic [3:0] t10, n10;
   logic       c10;
   logic [6:0] lv99, o99;
   logic [3:0] t99, n99;
   logic       c99;

   logic       cas_en;
   logic [6:0] s_out;
   logic [3:0] s_t, s_n;
   logic       s_co;
   logic [4:0] h_out;
   logic [3:0] h_t, h_n;
   logic       h_co;
   logic [6:0] lv_s;
   logic [4:0] lv_h;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   cnt_modn #(.MOD(60), .WIDTH(7)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
      .load(load), .load_val(load_val), .out(out),
      .bcd_tens(tens), .bcd_ones(ones), .co(co));

   cnt_modn #(.MOD(2), .WIDTH(1)) u_m2 (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
      .load(1'b0), .load_val(lv2), .out(o2),
      .bcd_tens(t2), .bcd_ones(n2), .co(c2));

   cnt_modn #(.MOD(10), .WIDTH(4)) u_m10 (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
      .load(1'b0), .load_val(lv10), .out(o10),
      .bcd_tens(t10), .bcd_ones(n10), .co(c10));

   cnt_modn #(.MOD(99), .WIDTH(7)) u_m99 (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
      .load(1'b0), .load_val(lv99), .out(o99),
      .bcd_tens(t99), .bcd_ones(n99), .co(c99));

   cnt_modn #(.MOD(60), .WIDTH(7)) u_sec (
      .clk(clk), .rst_n(rst_n), .en(cas_en), .up_dn(1'b1), .clr(1'b0),
      .load(1'b0), .load_val(lv_s), .out(s_out),
      .bcd_tens(s_t), .bcd_ones(s_n), .co(s_co));

   cnt_modn #(.MOD(24), .WIDTH(5)) u_hr (
      .clk(clk), .rst_n(rst_n), .en(s_co), .up_dn(1'b1), .clr(1'b0),
      .load(1'b0), .load_val(lv_h), .out(h_out),
      .bcd_tens(h_t), .bcd_ones(h_n), .co(h_co));

   task automatic chk(input string tag, input int obs, input int exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic l, input logic e,
                        input logic u, input logic [6:0] v);
      @(negedge clk);
      clr = c;
      load = l;
      en = e;
      up_dn = u;
      load_val = v;
   endtask

   task automatic chk60(input string tag, input int exp_out, input int exp_co);
      chk({tag, ".out"}, int'(out), exp_out);
      chk({tag, ".co"}, int'(co), exp_co);
      chk({tag, ".tens"}, int'(tens), exp_out / 10);
      chk({tag, ".ones"}, int'(ones), exp_out % 10);
   endtask

   task automatic chk_sw(input string tag, input int m, input int o,
                         input int t, input int n, input int c,
                         input int exp_out, input int exp_co);
      chk({tag, ".out"}, o, exp_out);
      chk({tag, ".range"}, int'(o < m), 1);
      chk({tag, ".co"}, c, exp_co);
      chk({tag, ".tens"}, t, o / 10);
      chk({tag, ".ones"}, n, o % 10);
   endtask

   initial begin
      int cnt_co;
      int hr_co_n;
      int hr_wrap;
      int prev_h;
      int e;

      rst_n = 1'b0;
      en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
      load_val = 7'd0;
      lv2 = '0; lv10 = '0; lv99 = '0; lv_s = '0; lv_h = '0;
      cas_en = 1'b0;

      repeat (3) tick();
      chk60("reset", 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk60("hold", 0, 0);
      end

      drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd0);
      repeat (3) tick();
      chk60("pre_async", 3, 0);
      en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk60("async_rst", 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd0);
      cnt_co = 0;
      for (int k = 1; k <= 125; k++) begin
         tick();
         chk60("upwrap", k % 60, (k % 60 == 0) ? 1 : 0);
         if (co) cnt_co++;
         if (k == 59) begin
            chk("up59.tens", int'(tens), 5);
            chk("up59.ones", int'(ones), 9);
         end
      end
      chk("upwrap.co_count", cnt_co, 2);

      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
      tick();
      chk60("clr", 0, 0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 7'd2);
      tick();
      chk60("load2", 2, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
      tick();
      chk60("dn1", 1, 0);
      tick();
      chk60("dn0", 0, 0);
      tick();
      chk60("dn59", 59, 1);
      tick();
      chk60("dn58", 58, 0);

      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd30);
      tick();
      chk60("prio_clr", 0, 0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 7'd75);
      tick();
      chk60("clamp75", 59, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd0);
      tick();
      chk60("clamp_wrap", 0, 1);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd0);
      tick();
      chk60("load0", 0, 0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd59);
      tick();
      chk60("load59", 59, 0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd37);
      tick();
      chk60("load37", 37, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
      tick();
      chk60("hold37", 37, 0);

      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd0);
      tick();
      chk60("dir_up", 1, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
      tick();
      chk60("dir_dn0", 0, 0);
      tick();
      chk60("dir_dn59", 59, 1);

      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
      tick();
      chk_sw("m2.clr", 2, int'(o2), int'(t2), int'(n2), int'(c2), 0, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd0);
      for (int k = 1; k <= 200; k++) begin
         tick();
         chk_sw("m2.up", 2, int'(o2), int'(t2), int'(n2), int'(c2),
                k % 2, (k % 2 == 0) ? 1 : 0);
         chk_sw("m10.up", 10, int'(o10), int'(t10), int'(n10), int'(c10),
                k % 10, (k % 10 == 0) ? 1 : 0);
         chk_sw("m99.up", 99, int'(o99), int'(t99), int'(n99), int'(c99),
                k % 99, (k % 99 == 0) ? 1 : 0);
      end

      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
      for (int k = 1; k <= 200; k++) begin
         tick();
         e = (2 - (k % 2)) % 2;
         chk_sw("m2.dn", 2, int'(o2), int'(t2), int'(n2), int'(c2),
                e, (k % 2 == 1) ? 1 : 0);
         e = (10 - (k % 10)) % 10;
         chk_sw("m10.dn", 10, int'(o10), int'(t10), int'(n10), int'(c10),
                e, (k % 10 == 1) ? 1 : 0);
         e = (99 - (k % 99)) % 99;
         chk_sw("m99.dn", 99, int'(o99), int'(t99), int'(n99), int'(c99),
                e, (k % 99 == 1) ? 1 : 0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);

      chk("cas.sec_start", int'(s_out), 0);
      chk("cas.hr_start", int'(h_out), 0);
      @(negedge clk);
      cas_en = 1'b1;
      hr_co_n = 0;
      hr_wrap = 0;
      prev_h = 0;
      for (int k = 1; k <= 2885; k++) begin
         tick();
         if (h_co) hr_co_n++;
         if (prev_h == 23 && int'(h_out) == 0) hr_wrap++;
         prev_h = int'(h_out);
         if (k == 2880) chk("cas.hr_pre", int'(h_out), 23);
      end
      @(negedge clk);
      cas_en = 1'b0;
      chk("cas.hr_wraps", hr_wrap, 2);
      chk("cas.hr_co", hr_co_n, 2);
      chk("cas.hr_end", int'(h_out), 0);
      chk("cas.sec_end", int'(s_out), 5);
      chk("cas.sec_bcd", int'(s_n), 5);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
